// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage MIPS-subset pipeline control logic:
//   - register/opcode field widths
//   - opcode and funct constants used by instruction classification
//   - fwd_sel_t : EX operand source select (RF / EX-MEM / MEM-WB)
//   - stage_track_t : per-stage shadow of the destination-register state
//   - ex_track_t : EX shadow, which also remembers the source registers
//   - fwd_select() : forwarding priority for one EX source operand
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int REG_W = 5;
  localparam int OP_W  = 6;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes that change register-write behaviour
  localparam logic [OP_W-1:0] FUNCT_JR = 6'h08;

  // EX operand source select; the encoding is what the datapath muxes expect
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Destination-register shadow held for each of EX, MEM and WB
  typedef struct packed {
    logic             valid;
    logic             we;
    logic             is_load;
    logic [REG_W-1:0] dst;
  } stage_track_t;

  // EX additionally keeps its sources so forwarding can be resolved there
  typedef struct packed {
    stage_track_t     trk;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
  } ex_track_t;

  // Newest producer wins: MEM is younger than WB, so it is checked first.
  function automatic fwd_sel_t fwd_select(input logic             use_src,
                                          input logic [REG_W-1:0] src,
                                          input stage_track_t     mem,
                                          input stage_track_t     wb);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (use_src) begin
      if (mem.valid && mem.we && (mem.dst == src)) begin
        sel = FWD_MEM;
      end else if (wb.valid && wb.we && (wb.dst == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/instr_class.sv
// -----------------------------------------------------------------------------
// instr_class
// Purely combinational decode of the hazard-relevant properties of one
// instruction.
// Ports:
//   op, funct   in  opcode / function field
//   rt, rd      in  candidate destination register fields
//   we          out instruction writes a register (never true for $0)
//   dst         out destination register index
//   is_load     out instruction is a load (result only available after MEM)
//   use_rs      out instruction reads rs
//   use_rt      out instruction reads rt
// Unknown opcodes decode as a nop: no write, no source use.
// -----------------------------------------------------------------------------
module instr_class
  import pipeline_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [OP_W-1:0]  funct,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  output logic             we,
  output logic [REG_W-1:0] dst,
  output logic             is_load,
  output logic             use_rs,
  output logic             use_rt
);

  logic writes;

  always_comb begin
    writes  = 1'b0;
    dst     = rd;
    is_load = 1'b0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    case (op)
      OP_RTYPE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        writes = (funct != FUNCT_JR);
        dst    = rd;
      end
      OP_LW: begin
        writes  = 1'b1;
        dst     = rt;
        is_load = 1'b1;
        use_rs  = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        writes = 1'b1;
        dst    = rt;
        use_rs = 1'b1;
      end
      OP_LUI: begin
        writes = 1'b1;
        dst    = rt;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_J: begin
        writes = 1'b0;
      end
      default: begin
        writes = 1'b0;
      end
    endcase
  end

  // $0 is hard-wired zero, so a write to it can never be a forwarding source.
  assign we = writes & (dst != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage MIPS-subset pipeline. Shadows
// the destination registers of EX, MEM and WB and produces load-use stall,
// control-hazard flushes and EX-stage forwarding selects.
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   id_valid              IF/ID holds a real instruction
//   id_op, id_funct       opcode / funct of the IF/ID instruction
//   id_rs, id_rt, id_rd   register fields of the IF/ID instruction
//   br_taken              branch in EX resolved taken this cycle
//   mem_stall             memory wait, freezes the whole pipeline
//   stall                 hold PC and IF/ID, bubble into ID/EX
//   flush_if_id           squash IF/ID on the next edge
//   flush_id_ex           squash ID/EX on the next edge
//   fwd_a, fwd_b          EX operand select (00 RF, 10 EX/MEM, 01 MEM/WB)
// Optional feature (macro HAZARD_CTRL_STATS_EN):
//   stall_count, flush_count   saturating 16-bit event counters
// -----------------------------------------------------------------------------
module hazard_ctrl
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [OP_W-1:0]  id_op,
  input  logic [OP_W-1:0]  id_funct,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             br_taken,
  input  logic             mem_stall,
  output logic             stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [15:0]      stall_count,
  output logic [15:0]      flush_count
`endif
);

  ex_track_t    ex_q, ex_d;
  stage_track_t mem_q, mem_d;
  stage_track_t wb_q, wb_d;

  logic             id_we;
  logic [REG_W-1:0] id_dst;
  logic             id_is_load;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             load_use;
  fwd_sel_t         fwd_a_sel;
  fwd_sel_t         fwd_b_sel;

  instr_class u_id_class (
    .op      (id_op),
    .funct   (id_funct),
    .rt      (id_rt),
    .rd      (id_rd),
    .we      (id_we),
    .dst     (id_dst),
    .is_load (id_is_load),
    .use_rs  (id_use_rs),
    .use_rt  (id_use_rt)
  );

  // Hazard equations. The consumer in ID can only be served by a load once
  // the load has left MEM, so a load in EX feeding ID costs one bubble.
  // A taken branch squashes the consumer anyway, and a memory freeze holds
  // everything, so both suppress the stall. Reset forces every output quiet
  // even though flush is otherwise driven straight from the inputs.
  always_comb begin
    load_use = id_valid & ex_q.trk.valid & ex_q.trk.is_load & ex_q.trk.we &
               ((id_use_rs & (id_rs == ex_q.trk.dst)) |
                (id_use_rt & (id_rt == ex_q.trk.dst)));
    stall       = load_use & ~br_taken & ~mem_stall & ~rst;
    flush_if_id = (br_taken | (id_valid & (id_op == OP_J))) & ~mem_stall & ~rst;
    flush_id_ex = br_taken & ~mem_stall & ~rst;
  end

  // Forwarding is resolved for the instruction now in EX; a bubble has both
  // use bits clear and therefore always selects the register file.
  always_comb begin
    fwd_a_sel = fwd_select(ex_q.use_rs, ex_q.rs, mem_q, wb_q);
    fwd_b_sel = fwd_select(ex_q.use_rt, ex_q.rt, mem_q, wb_q);
    fwd_a     = fwd_a_sel;
    fwd_b     = fwd_b_sel;
  end

  // Shadow pipeline advance. A memory wait holds every stage. Otherwise
  // each stage shifts down, and EX takes either the decoded IF/ID
  // instruction or a bubble when IF/ID is empty, stalled or being flushed.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!mem_stall) begin
      wb_d  = mem_q;
      mem_d = ex_q.trk;
      if (stall || br_taken || !id_valid) begin
        ex_d = '0;
      end else begin
        ex_d.trk.valid   = 1'b1;
        ex_d.trk.we      = id_we;
        ex_d.trk.is_load = id_is_load;
        ex_d.trk.dst     = id_dst;
        ex_d.rs          = id_rs;
        ex_d.rt          = id_rt;
        ex_d.use_rs      = id_use_rs;
        ex_d.use_rt      = id_use_rt;
      end
    end
  end

  // Tracking registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // A load that has reached WB no longer constrains anything; the flag only
  // rides along so every stage carries the same record.
  logic unused_wb_is_load;
  assign unused_wb_is_load = wb_q.is_load;

`ifdef HAZARD_CTRL_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Saturating event counters; they stop at all-ones instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
    if (flush_if_id && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule
